// File: rtl/iiitb_pgc.sv
// Up/down Gray-code counter with load, wrap/saturate mode, terminal-count and overflow pulse.
// Define GC_STEP_CHK_EN to build the sticky single-bit-change checker behind step_err.
module iiitb_pgc #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_count,
    output logic             tc,
    output logic             ovf,
    output logic             step_err
);

    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic             SAT_MODE = (SATURATE != 0);

    // Prefix-XOR from the MSB down recovers the binary value of a Gray code.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             ovf_nxt;

    assign tc = dir ? (cnt == '1) : (cnt == '0);

    // Next binary count; load wins over a step request.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = 1'b0;
        if (load) begin
            cnt_nxt = gray_to_bin(load_gray);
        end else if (enable) begin
            ovf_nxt = tc;
            if (!(tc && SAT_MODE)) begin
                cnt_nxt = dir ? (cnt + WIDTH'(1)) : (cnt - WIDTH'(1));
            end
        end
    end

    assign gray_nxt = cnt_nxt ^ (cnt_nxt >> 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= RST_BIN;
            gray_count <= RST_GRAY;
            ovf        <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            gray_count <= gray_nxt;
            ovf        <= ovf_nxt;
        end
    end

`ifdef GC_STEP_CHK_EN
    logic [WIDTH-1:0] prev_gray;
    logic [WIDTH-1:0] gray_diff;
    logic             stepped;
    logic             step_c;

    // Only real count steps are checked; loads, clips and holds are exempt.
    assign step_c    = !load && enable && !(tc && SAT_MODE);
    assign gray_diff = prev_gray ^ gray_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_gray <= RST_GRAY;
            stepped   <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            prev_gray <= gray_count;
            stepped   <= step_c;
            // x & (x-1) is nonzero exactly when more than one bit is set.
            if (stepped && ((gray_diff & (gray_diff - WIDTH'(1))) != '0)) begin
                step_err <= 1'b1;
            end
        end
    end
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: doc/iiitb_pgc.md
Name: iiitb_pgc

Overview:
Parametrised up/down Gray-code counter, the next-generation counter block. It holds a binary count and presents a registered Gray-coded output of configurable width. It adds direction control, synchronous Gray-value load, selectable wrap/saturate mode, a terminal-count flag and an overflow/underflow pulse. It is intended for pointer generation (e.g. async FIFO pointers) and position encoders where a glitch-free single-bit-change output is required.

Parameters:
WIDTH, 8, counter and output width in bits; legal range 2..32.
SATURATE, 0, 0 = wrap at the ends of the range, 1 = hold at the terminal value.
RESET_VAL, 0, binary count value loaded on reset; gray_count resets to RESET_VAL ^ (RESET_VAL >> 1).

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  count step request for this cycle
dir  input  1  1 = count up, 0 = count down; sampled with enable
load  input  1  synchronous load strobe
load_gray  input  WIDTH  Gray-coded value to load
gray_count  output  WIDTH  registered Gray-coded count
tc  output  1  combinational terminal-count flag
ovf  output  1  registered one-cycle wrap/clip pulse
step_err  output  1  sticky single-bit-change violation flag (see Optional Feature)

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high. All state changes on the rising edge of clk.
- Internal state: binary count cnt[WIDTH-1:0], registered gray_count, ovf, step_err.
- gray_count always equals cnt ^ (cnt >> 1). Both are registered from the same next-state value, so there is no extra pipeline stage. An input applied before edge n is visible on gray_count after edge n.
- Priority per edge: reset > load > enable.
- reset=1: cnt <= RESET_VAL; gray_count <= gray(RESET_VAL); ovf <= 0; step_err <= 0. Reset overrides a load or step in the same cycle, including mid-count.
- load=1 (no reset): cnt <= gray-to-binary(load_gray), where b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] ^ g[i]. gray_count <= load_gray. ovf <= 0. enable is ignored in a load cycle. Any WIDTH-bit value is legal.
- enable=1, dir=1: cnt <= cnt + 1, modulo 2^WIDTH.
- enable=1, dir=0: cnt <= cnt - 1, modulo 2^WIDTH.
- enable=0: hold all state; ovf <= 0.
- Terminal value: MAX = 2^WIDTH-1 when dir=1; 0 when dir=0.
- tc = (cnt == terminal value for the current dir). tc is combinational on cnt and dir and is independent of enable.
- Step at terminal value (enable=1 and tc=1):
  - SATURATE=0: count wraps (MAX -> 0 up, 0 -> MAX down); ovf=1 for exactly the next cycle.
  - SATURATE=1: cnt and gray_count hold; ovf=1 for the next cycle. Repeated enables at the terminal value keep ovf high on every following cycle.
- ovf is 0 after any non-terminal step, load, hold or reset.
- A direction change between cycles is legal; the next step goes in the new direction with no dead cycle.
- In a non-load step cycle, gray_count changes in exactly one bit. In saturate clip and hold cycles it changes in zero bits.

Optional Feature:
Macro GC_STEP_CHK_EN.
- Defined: a checker register holds the previous gray_count. On a cycle following a step (not load, not reset), if popcount(prev ^ gray_count) > 1, step_err is set and stays set (sticky) until reset. Hold, clip and load cycles are exempt.
- Undefined: the checker logic is not built; step_err is tied to 0. The port list is identical in both builds.

Test Plan:
- WIDTH=8, reset then enable=1, dir=1 for 5 cycles -> gray_count 0x00,0x01,0x03,0x02,0x06,0x07; tc=0; ovf=0.
- WIDTH=8, SATURATE=0, load_gray=0x80 (bin 255), dir=1, one enable -> tc=1 before the edge; gray_count=0x00 after; ovf=1 for one cycle. Then dir=0, one enable -> gray_count=0x80 and ovf=1.
- WIDTH=8, SATURATE=1, count at bin 255, 3 enables up -> gray_count stays 0x80; ovf=1 for 3 consecutive cycles, then 0 once enable drops.
- Load load_gray=0xC0 (bin 0x80) with enable=1 in the same cycle -> gray_count=0xC0 (no step). Next enable up -> 0xC1; next enable down -> 0xC0.
- Mid-count, reset=1 with load=1 and enable=1 (RESET_VAL=5) -> gray_count=0x07, ovf=0, step_err=0.
- With GC_STEP_CHK_EN: 600 cycles of random enable/dir/load, WIDTH=4 and WIDTH=8 -> step_err stays 0. Without the macro, step_err is constant 0.
